// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Purpose  : Shared UART line constants, tick divider helper and the
//            receiver state encoding. Used by both the RX and TX sides.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

  localparam int SERIAL_CLK_FREQ   = 25000000;
  localparam int SERIAL_BAUD_RATE  = 115200;
  localparam int SERIAL_OVERSAMPLE = 8;

  // Clocks per sample tick; integer division, so a bit is slightly short.
  function automatic int serial_tick_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_if
// Purpose  : Serial line input plus received-byte outputs of the receiver.
//            slave  = the receiver itself, master = line driver / consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  modport slave  (input  rx, output data, output valid, output framing_error, output busy);
  modport master (output rx, input  data, input  valid, input  framing_error, input  busy);
endinterface
`default_nettype wire

// File: rtl/serial_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : serial_baud_tick
// Purpose  : Free-running divider producing a one-clock tick every
//            TICK_DIV clocks. Runs regardless of receiver/transmitter state.
// Revision : 1.0 - initial release
// ============================================================================
module serial_baud_tick #(
  parameter int TICK_DIV   = 27,
  parameter int TICK_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  tick_o,
  output logic [TICK_WIDTH-1:0] counter_o
);

  localparam logic [TICK_WIDTH-1:0] CNT_LAST = TICK_WIDTH'(TICK_DIV - 1);

  logic [TICK_WIDTH-1:0] counter_q;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
    end else if (counter_q == CNT_LAST) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_q + TICK_WIDTH'(1);
    end
  end

  assign tick_o    = (counter_q == CNT_LAST);
  assign counter_o = counter_q;

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Purpose  : 8N1 UART receiver. Oversamples a synchronised rx line, rejects
//            start-bit glitches, pulses valid on a good frame and
//            framing_error on a low stop bit, then waits out a held-low line.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_FREQ   = SERIAL_CLK_FREQ,
  parameter int BAUD_RATE  = SERIAL_BAUD_RATE,
  parameter int OVERSAMPLE = SERIAL_OVERSAMPLE,  // even, >= 4
  parameter int TICK_DIV   = serial_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE),
  parameter int TICK_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  serial_rx_if.slave  bus
);

  localparam int                SMP_W    = $clog2(OVERSAMPLE);
  localparam logic [SMP_W-1:0]  SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'(OVERSAMPLE - 1);

  logic                  w_tick;
  logic [TICK_WIDTH-1:0] w_tick_cnt_unused;

  serial_baud_tick #(
    .TICK_DIV   (TICK_DIV),
    .TICK_WIDTH (TICK_WIDTH)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .tick_o    (w_tick),
    .counter_o (w_tick_cnt_unused)
  );

  logic [1:0] sync_q;
  logic       w_rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign w_rx_s = sync_q[1];

  rx_state_t        state_q;
  logic [SMP_W-1:0] smp_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             busy_q;

  // Frame state machine; advances only on sample ticks, outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (w_tick) begin
        case (state_q)
          IDLE: begin
            if (!w_rx_s) begin
              state_q <= START;
              smp_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            // Re-check the line near the middle of the start bit.
            if (smp_q == SMP_MID) begin
              if (w_rx_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= DATA;
                smp_q   <= '0;
                bit_q   <= '0;
              end
            end else begin
              smp_q <= smp_q + SMP_W'(1);
            end
          end
          DATA: begin
            // LSB arrives first; right shift leaves bit 0 in shift_q[0].
            if (smp_q == SMP_LAST) begin
              smp_q   <= '0;
              shift_q <= {w_rx_s, shift_q[7:1]};
              if (bit_q == 3'd7) begin
                state_q <= STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end else begin
              smp_q <= smp_q + SMP_W'(1);
            end
          end
          STOP: begin
            // Leave at mid-stop so a start edge right after it is caught.
            if (smp_q == SMP_LAST) begin
              if (w_rx_s) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BREAK;
              end
            end else begin
              smp_q <= smp_q + SMP_W'(1);
            end
          end
          BREAK: begin
            // Hold here while the line stays low to avoid repeated frames.
            if (w_rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data          = data_q;
  assign bus.valid         = valid_q;
  assign bus.framing_error = ferr_q;
  assign bus.busy          = busy_q;

endmodule
`default_nettype wire
